// File: rtl/lbp_image_host.sv
// rtl/lbp_image_host.sv - gray image store and LBP result capture for the LBP engine
// Optional: define LBP_HOST_BORDER_CHECK_EN to add the sticky err output.
module lbp_image_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  output logic          done,
  output logic [AW-1:0] wr_count,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
`ifdef LBP_HOST_BORDER_CHECK_EN
  ,
  output logic          err
`endif
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = AW - CW;
  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr;
  logic [7:0]    img [NPIX];
  logic [7:0]    res [NPIX];
  logic          img_we;
  logic          res_we;

  function automatic logic is_border(input logic [AW-1:0] a);
    return (a[AW-1:CW] == '0) || (a[AW-1:CW] == ROW_LAST) ||
           (a[CW-1:0] == '0)  || (a[CW-1:0] == COL_LAST);
  endfunction

  assign img_we = (state_q == S_LOAD)  && load_valid;
  assign res_we = (state_q == S_SERVE) && lbp_valid;

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    gray_ready = 1'b0;
    done       = 1'b0;
    gray_data  = 8'h00;
    case (state_q)
      S_LOAD: begin
        load_ready = 1'b1;
        if (img_we && (ptr == LAST_ADDR)) state_d = S_SERVE;
      end
      S_SERVE: begin
        gray_ready = 1'b1;
        // zero-latency read: engine samples gray_data on the next edge
        if (gray_req) gray_data = img[gray_addr];
        if (finish) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD;
      ptr      <= '0;
      wr_count <= '0;
      rd_data  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (img_we) ptr <= ptr + 1'b1;
      if (res_we && (wr_count != LAST_ADDR)) wr_count <= wr_count + 1'b1;
      // border pixels have no LBP value, so they always read back as zero
      rd_data <= is_border(rd_addr) ? 8'h00 : res[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (img_we) img[ptr] <= load_data;
    if (res_we) res[lbp_addr] <= lbp_data;
  end

`ifdef LBP_HOST_BORDER_CHECK_EN
  localparam logic [AW-1:0] EXP_COUNT = AW'((IMG_W - 2) * (IMG_H - 2));
  logic [AW-1:0] count_after;

  // count including a write that lands on the same edge as finish
  assign count_after = (res_we && (wr_count != LAST_ADDR)) ? wr_count + 1'b1 : wr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      if (res_we && is_border(lbp_addr)) err <= 1'b1;
      if ((state_q == S_SERVE) && finish && (count_after != EXP_COUNT)) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lbp_image_host.sv
// tb/tb_lbp_image_host.sv - randomized self-checking bench for lbp_image_host
// Optional: define LBP_HOST_BORDER_CHECK_EN to also check the err output.
module tb_lbp_image_host;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;
  logic          done;
  logic [AW-1:0] wr_count;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
`ifdef LBP_HOST_BORDER_CHECK_EN
  logic          err;
`endif

  lbp_image_host #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .gray_ready(gray_ready),
    .gray_req(gray_req),
    .gray_addr(gray_addr),
    .gray_data(gray_data),
    .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr),
    .lbp_data(lbp_data),
    .finish(finish),
    .done(done),
    .wr_count(wr_count),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
`ifdef LBP_HOST_BORDER_CHECK_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] img_m [NPIX];
  logic [7:0] res_m [NPIX];
  int         wr_n;
  int         written[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit border(input int a);
    return (a / IMG_W == 0) || (a / IMG_W == IMG_H - 1) ||
           (a % IMG_W == 0) || (a % IMG_W == IMG_W - 1);
  endfunction

  function automatic logic [7:0] rd_exp(input int a);
    return border(a) ? 8'h00 : res_m[a];
  endfunction

  task automatic lbp_write(input int a, input logic [7:0] d);
    lbp_valid = 1'b1;
    lbp_addr  = AW'(a);
    lbp_data  = d;
    tick();
    lbp_valid = 1'b0;
    res_m[a]  = d;
    wr_n++;
    written.push_back(a);
  endtask

  task automatic readback(input string tag, input int a);
    rd_addr = AW'(a);
    tick();
    check(tag, 32'(rd_data), 32'(rd_exp(a)));
  endtask

  initial begin
    int i;
    int a;
    logic [7:0] old;

    reset = 1'b1; load_valid = 1'b0; load_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; rd_addr = '0;
    wr_n = 0;
    repeat (3) tick();
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_gray_ready", 32'(gray_ready), 32'd0);
    check("rst_gray_data",  32'(gray_data),  32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_wr_count",   32'(wr_count),   32'd0);
    check("rst_rd_data",    32'(rd_data),    32'd0);
    reset = 1'b0;
    tick();

    // partial load, aborted by an asynchronous reset
    for (int k = 0; k < 5000; k++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      tick();
    end
    load_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("abort_load_ready", 32'(load_ready), 32'd1);
    check("abort_gray_ready", 32'(gray_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // full load with random gaps; stray lbp_valid/finish must be ignored
    i = 0;
    while (i < NPIX) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        lbp_valid  = 1'b1;
        lbp_addr   = AW'(129);
        lbp_data   = 8'hFF;
        finish     = 1'($urandom);
      end else begin
        load_valid = 1'b1;
        load_data  = 8'($urandom);
        img_m[i]   = load_data;
        lbp_valid  = 1'b0;
        finish     = 1'b0;
        if ((i % 4096 == 0) || (i == NPIX - 1))
          check($sformatf("load_ready_px%0d", i), 32'(load_ready), 32'd1);
        i++;
      end
      tick();
    end
    load_valid = 1'b0; lbp_valid = 1'b0; finish = 1'b0;
    check("serve_load_ready", 32'(load_ready), 32'd0);
    check("serve_gray_ready", 32'(gray_ready), 32'd1);
    check("serve_done",       32'(done),       32'd0);
    check("serve_wr_count",   32'(wr_count),   32'd0);

    // combinational gray reads; load_valid in SERVE must not disturb the image
    gray_req = 1'b1; gray_addr = AW'(129);
    #1 check("gray_129", 32'(gray_data), 32'(img_m[129]));
    gray_req = 1'b0;
    #1 check("gray_noreq", 32'(gray_data), 32'd0);
    for (int k = 0; k < 24; k++) begin
      a = (k == 0) ? 0 : (k == 1) ? NPIX - 1 : int'($urandom_range(0, NPIX - 1));
      gray_req   = (k < 2) ? 1'b1 : 1'($urandom);
      gray_addr  = AW'(a);
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      #1 check($sformatf("gray_rand_%0d", a), 32'(gray_data),
               gray_req ? 32'(img_m[a]) : 32'd0);
      tick();
    end
    load_valid = 1'b0; gray_req = 1'b0;

    // result writes and readback
    lbp_write(129, 8'hA5);
    lbp_write(16254, 8'h3C);
    readback("rd_129", 129);
    readback("rd_16254", 16254);
    lbp_write(0, 8'h5A);
    lbp_write(127, 8'h66);
    lbp_write(128, 8'h77);
    lbp_write(16383, 8'h99);
    readback("rd_border_0", 0);
    readback("rd_border_127", 127);
    readback("rd_border_128", 128);
    readback("rd_border_16383", 16383);
    for (int k = 0; k < 20; k++)
      lbp_write(int'($urandom_range(0, NPIX - 1)), 8'($urandom));
    foreach (written[k]) readback($sformatf("rd_rand_%0d", written[k]), written[k]);
    check("wr_count_serve", 32'(wr_count), 32'(wr_n));

    // write and read of the same address on one edge returns the old value
    old = rd_exp(129);
    rd_addr = AW'(129); lbp_valid = 1'b1; lbp_addr = AW'(129); lbp_data = 8'hC3;
    tick();
    lbp_valid = 1'b0; res_m[129] = 8'hC3; wr_n++;
    check("rw_same_old", 32'(rd_data), 32'(old));
    tick();
    check("rw_same_new", 32'(rd_data), 32'hC3);
`ifdef LBP_HOST_BORDER_CHECK_EN
    check("err_border_write", 32'(err), 32'd1);
`endif

    // final write together with finish
    lbp_valid = 1'b1; finish = 1'b1; lbp_addr = AW'(16254); lbp_data = 8'h7E;
    tick();
    lbp_valid = 1'b0; finish = 1'b0; res_m[16254] = 8'h7E; wr_n++;
    check("fin_done",       32'(done),       32'd1);
    check("fin_gray_ready", 32'(gray_ready), 32'd0);
    check("fin_load_ready", 32'(load_ready), 32'd0);
    check("fin_wr_count",   32'(wr_count),   32'(wr_n));
    gray_req = 1'b1; gray_addr = AW'(129);
    #1 check("fin_gray_data", 32'(gray_data), 32'd0);
    readback("fin_rd_16254", 16254);
    lbp_valid = 1'b1; lbp_addr = AW'(16254); lbp_data = 8'h11;
    tick();
    lbp_valid = 1'b0;
    check("done_wr_ignored", 32'(wr_count), 32'(wr_n));
    readback("done_rd_16254", 16254);
`ifdef LBP_HOST_BORDER_CHECK_EN
    check("err_sticky", 32'(err), 32'd1);
`endif

    // asynchronous reset from DONE, between clock edges
    #2 reset = 1'b1;
    #1;
    check("areset_done",       32'(done),       32'd0);
    check("areset_wr_count",   32'(wr_count),   32'd0);
    check("areset_rd_data",    32'(rd_data),    32'd0);
    check("areset_load_ready", 32'(load_ready), 32'd1);
    check("areset_gray_ready", 32'(gray_ready), 32'd0);
    check("areset_gray_data",  32'(gray_data),  32'd0);
`ifdef LBP_HOST_BORDER_CHECK_EN
    check("areset_err", 32'(err), 32'd0);
`endif
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
